// File: rtl/rename_pkg.sv
// Shared sizing, types and bit-count helpers for the rename-stage preg allocator.
// The group width and register-file sizes are configured here.
package rename_pkg;

   localparam int GROUP_W  = 4;
   localparam int AREG_NUM = 32;
   localparam int PREG_NUM = 64;
   localparam int FL_DEPTH = PREG_NUM - AREG_NUM;
   localparam int PREG_W   = $clog2(PREG_NUM);
   localparam int IDX_W    = $clog2(FL_DEPTH);
   localparam int PTR_W    = IDX_W + 1;
   localparam int CNT_W    = $clog2(GROUP_W + 1);
   localparam int FCNT_W   = $clog2(FL_DEPTH + 1);

   typedef logic [PREG_W-1:0] preg_t;
   typedef preg_t preg_vec_t [GROUP_W-1:0];
   typedef logic [PTR_W-1:0] ptr_t;

   function automatic logic [CNT_W-1:0] popcount(input logic [GROUP_W-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < GROUP_W; i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

   // Number of set bits strictly below position idx.
   function automatic logic [CNT_W-1:0] prefix_cnt(input logic [GROUP_W-1:0] v, input int idx);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < GROUP_W; i++) begin
         if (i < idx) c = c + CNT_W'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/preg_free_list.sv
// Circular free list of physical registers: multi-pop at head, compacting multi-push at tail,
// and a committed head pointer that speculative pops are rewound to on flush.
module preg_free_list
   import rename_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pop_en,
   input  logic [GROUP_W-1:0]  pop_need,
   output preg_vec_t           pop_preg,
   input  logic [GROUP_W-1:0]  push_valid,
   input  preg_vec_t           push_preg,
   input  logic [CNT_W-1:0]    retire_cnt,
   input  logic                flush,
   output logic [FCNT_W-1:0]   free_count
);

   if ((FL_DEPTH & (FL_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("FL_DEPTH must be a power of two");
   end

   preg_t fifo [FL_DEPTH];
   ptr_t  head;
   ptr_t  tail;
   ptr_t  commit_head;
   ptr_t  commit_head_nxt;
   ptr_t  tail_nxt;

   assign commit_head_nxt = commit_head + ptr_t'(retire_cnt);
   assign tail_nxt        = tail + ptr_t'(popcount(push_valid));
   assign free_count      = FCNT_W'(tail - head);

   always_comb begin
      for (int i = 0; i < GROUP_W; i++) begin
         pop_preg[i] = fifo[IDX_W'(head + ptr_t'(prefix_cnt(pop_need, i)))];
      end
   end

   // Valid free slots are packed together so pushes land contiguously at tail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FL_DEPTH; i++) fifo[i] <= preg_t'(AREG_NUM + i);
      end else begin
         for (int i = 0; i < GROUP_W; i++) begin
            if (push_valid[i]) begin
               fifo[IDX_W'(tail + ptr_t'(prefix_cnt(push_valid, i)))] <= push_preg[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head        <= '0;
         commit_head <= '0;
         tail        <= ptr_t'(FL_DEPTH);
      end else begin
         tail        <= tail_nxt;
         commit_head <= commit_head_nxt;
         if (flush) begin
            head <= commit_head_nxt;
         end else if (pop_en) begin
            head <= head + ptr_t'(popcount(pop_need));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (ptr_t'(tail_nxt - commit_head_nxt) <= ptr_t'(FL_DEPTH))
            else $error("free list overflow");
         assert (ptr_t'(head - commit_head) >= ptr_t'(retire_cnt))
            else $error("retire passes allocation head");
         for (int i = 0; i < GROUP_W; i++) begin
            assert (!push_valid[i] || (push_preg[i] != '0))
               else $error("preg 0 freed");
         end
      end
   end

endmodule

// File: rtl/rename_preg_alloc_ctrl.sv
// Rename-stage allocator: handshakes a decode group, pops one free preg per needing slot
// and registers the allocation toward RAT-write/dispatch.
module rename_preg_alloc_ctrl
   import rename_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [GROUP_W-1:0]              in_rd_need,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [GROUP_W-1:0]              out_rd_need,
   output logic [GROUP_W-1:0][PREG_W-1:0]  out_preg,
   input  logic [GROUP_W-1:0]              free_valid,
   input  logic [GROUP_W-1:0][PREG_W-1:0]  free_preg,
   input  logic [CNT_W-1:0]                retire_alloc_cnt,
   input  logic                            flush,
   output logic [FCNT_W-1:0]               free_count
);

   logic                            accept;
   logic [CNT_W-1:0]                need_cnt;
   preg_vec_t                       pop_preg;
   preg_vec_t                       push_preg;
   logic [GROUP_W-1:0][PREG_W-1:0]  alloc_p0;

   assign need_cnt = popcount(in_rd_need);
   assign in_ready = !flush && (!out_valid || out_ready) && (free_count >= FCNT_W'(need_cnt));
   assign accept   = in_valid && in_ready;

   always_comb begin
      for (int i = 0; i < GROUP_W; i++) begin
         push_preg[i] = free_preg[i];
         alloc_p0[i]  = in_rd_need[i] ? pop_preg[i] : '0;
      end
   end

   preg_free_list u_free_list (
      .clk        (clk),
      .rst_n      (rst_n),
      .pop_en     (accept),
      .pop_need   (in_rd_need),
      .pop_preg   (pop_preg),
      .push_valid (free_valid),
      .push_preg  (push_preg),
      .retire_cnt (retire_alloc_cnt),
      .flush      (flush),
      .free_count (free_count)
   );

   // p0 -> p1: allocation register toward dispatch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_rd_need <= '0;
         out_preg    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_rd_need <= in_rd_need;
         out_preg    <= alloc_p0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
